// File: rtl/uart_resp_tx.sv
// 8N1 UART transmitter that sends one I2C read result as a fixed response frame.
// Optional checksum byte: define UART_TX_CHKSUM_EN to append B5 = B1^B2^B3^B4.
module uart_resp_tx #(
  parameter int          CLK_FREQ = 50000000,
  parameter int          BAUD     = 115200,
  parameter int          BAUD_DIV = CLK_FREQ / BAUD,
  parameter logic [7:0]  HEADER   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [6:0]  rsp_dev_addr,
  input  logic [7:0]  rsp_reg_addr,
  input  logic [15:0] rsp_data,
  output logic        TXD,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  // Handshake: a response transfers on a rising edge where rsp_valid && rsp_ready;
  // rsp_ready is high only in IDLE, and inputs are ignored while a frame is sent.

  if (BAUD_DIV < 2 || BAUD <= 0 || CLK_FREQ <= 0) begin : g_bad_cfg
    $error("uart_resp_tx: BAUD_DIV must be >= 2");
  end

  localparam int CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

`ifdef UART_TX_CHKSUM_EN
  localparam logic [2:0] LAST_BYTE = 3'd5;
`else
  localparam logic [2:0] LAST_BYTE = 3'd4;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [2:0]    byte_q, byte_d;
  logic          txd_q, txd_d;
  logic [6:0]    dev_q, dev_d;
  logic [7:0]    reg_q, reg_d;
  logic [15:0]   data_q, data_d;

  logic          accept;
  logic          baud_end;
  logic [7:0]    cur_byte;

  assign rsp_ready = (state_q == S_IDLE);
  assign busy      = ~rsp_ready;
  assign TXD       = txd_q;
  assign dbg_state = state_q;
  assign accept    = rsp_valid && rsp_ready;
  assign baud_end  = (baud_q == BAUD_LAST);

`ifdef UART_TX_CHKSUM_EN
  logic [7:0] chk;
  // Built from the latched fields, so it is settled long before B5 starts.
  assign chk = {dev_q, 1'b1} ^ reg_q ^ data_q[15:8] ^ data_q[7:0];
`endif

  always_comb begin
    cur_byte = 8'hFF;
    case (byte_q)
      3'd0:    cur_byte = HEADER;
      3'd1:    cur_byte = {dev_q, 1'b1};
      3'd2:    cur_byte = reg_q;
      3'd3:    cur_byte = data_q[15:8];
      3'd4:    cur_byte = data_q[7:0];
`ifdef UART_TX_CHKSUM_EN
      3'd5:    cur_byte = chk;
`endif
      default: cur_byte = 8'hFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    txd_d   = txd_q;
    dev_d   = dev_q;
    reg_d   = reg_q;
    data_d  = data_q;

    if (state_q != S_IDLE) begin
      baud_d = baud_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        byte_d = '0;
        txd_d  = 1'b1;
        if (accept) begin
          dev_d   = rsp_dev_addr;
          reg_d   = rsp_reg_addr;
          data_d  = rsp_data;
          txd_d   = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          txd_d   = cur_byte[0];
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            txd_d   = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
            txd_d = cur_byte[bit_q + 3'd1];
          end
        end
      end
      S_STOP: begin
        if (baud_end) begin
          if (byte_q == LAST_BYTE) begin
            txd_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Next start bit follows the stop bit with no idle time.
            byte_d  = byte_q + 3'd1;
            txd_d   = 1'b0;
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      txd_q   <= 1'b1;
      dev_q   <= '0;
      reg_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      txd_q   <= txd_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      data_q  <= data_d;
    end
  end

endmodule
